multdiv_unit: RTL and testbench

Iterative signed multiply/divide responder for the execute stage. It fills the reserved mult/div slot in the execute stage. The execute stage is the initiator: it issues a one-cycle start with operands and destination register. This block computes over multiple cycles and returns the result, the destination register and the exception status on a one-cycle ready pulse, for forwarding and writeback.

---
 rtl/multdiv_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_multdiv_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// -----------------------------------------------------------------------------
// multdiv_unit
//
// Iterative signed multiply/divide unit for the execute stage. The execute
// stage issues a one-cycle start with operands and a destination register.
// This unit works on operand magnitudes over ITER cycles and then returns the
// result, destination register and exception flag on a one-cycle ready pulse.
//
//   multiply : radix-2 shift-add over a 2*WIDTH accumulator, one bit per cycle
//   divide   : restoring division, one quotient bit per cycle, truncating
//   sign     : A[msb]^B[msb], applied on the way into DONE
//   exception: multiply overflow, divide-by-zero, INT_MIN / -1
//              -> rd_out = STATUS_REG, data_result = MUL_ERR_CODE/DIV_ERR_CODE
//
// Optional feature, macro MULTDIV_EARLY_OUT_EN:
//   defined   - a zero dividend/multiplicand (or zero multiplier) finishes at
//               E0+1 with result 0 and no exception
//   undefined - zero operands take the full-length path
//
// Ports
//   clock           in   system clock, rising edge
//   reset           in   synchronous, active-high; aborts any operation
//   ctrl_MULT       in   one-cycle multiply start (wins over ctrl_DIV)
//   ctrl_DIV        in   one-cycle divide start
//   data_operandA   in   multiplicand / dividend, two's complement
//   data_operandB   in   multiplier / divisor, two's complement
//   rd_in           in   destination register of the issuing instruction
//   busy            out  operation in flight; starts are ignored while high
//   data_resultRDY  out  one-cycle pulse; result fields valid this cycle
//   data_result     out  product/quotient, or error code on exception
//   data_exception  out  overflow or divide-by-zero, valid with RDY
//   rd_out          out  captured rd_in, or STATUS_REG on exception
// -----------------------------------------------------------------------------
module multdiv_unit #(
  parameter int WIDTH        = 32,
  parameter int ITER         = 32,
  parameter int STATUS_REG   = 30,
  parameter int MUL_ERR_CODE = 4,
  parameter int DIV_ERR_CODE = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [4:0]       rd_in,
  output logic             busy,
  output logic             data_resultRDY,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic [4:0]       rd_out
);

  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_acc;    // multiply: {partial product, remaining multiplier}
  logic [WIDTH-1:0]   r_opnd;   // |A| for multiply, |B| for divide
  logic [WIDTH:0]     r_rem;    // divide partial remainder
  logic [WIDTH-1:0]   r_quo;    // divide: dividend bits shifting out, quotient shifting in
  logic               r_sign;
  logic               r_exc;    // exception known at start (divide-by-zero, INT_MIN/-1)
  logic [4:0]         r_rd;

  logic [WIDTH-1:0]   r_result;
  logic               r_exception;
  logic [4:0]         r_rd_out;

  // ---------------------------------------------------------------------------
  // Start decode
  // ---------------------------------------------------------------------------
  logic             w_start;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_div_zero;
  logic             w_div_ovf;
  logic             w_early;
  logic             w_skip;
  logic             w_last;

  assign w_start = ((r_state == S_IDLE) || (r_state == S_DONE)) && (ctrl_MULT || ctrl_DIV);

  // INT_MIN maps onto itself, which is the correct unsigned magnitude 2^(WIDTH-1).
  assign w_mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  assign w_div_zero = !ctrl_MULT && (data_operandB == '0);
  assign w_div_ovf  = !ctrl_MULT && (data_operandA == {1'b1, {(WIDTH-1){1'b0}}})
                                 && (data_operandB == '1);

`ifdef MULTDIV_EARLY_OUT_EN
  assign w_early = (data_operandA == '0) || (ctrl_MULT && (data_operandB == '0));
`else
  assign w_early = 1'b0;
`endif

  // Skipping ops preload the counter as already finished, so they spend one
  // cycle in MULT/DIV and reach DONE at E0+1 through the normal exit.
  assign w_skip = w_div_zero || w_early;
  assign w_last = (r_count == CW'(ITER));

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH+1:0]   w_shift;
  logic               w_ge;
  logic [WIDTH:0]     w_sub;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_mul_ovf;
  logic [WIDTH-1:0]   w_quo;

  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);

  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_ge    = (w_shift >= {2'b00, r_opnd});
  assign w_sub   = w_shift[WIDTH:0] - {1'b0, r_opnd};

  assign w_prod = r_sign ? -r_acc : r_acc;
  // The signed product fits in WIDTH bits only when its top WIDTH+1 bits agree.
  assign w_mul_ovf = !((&w_prod[2*WIDTH-1:WIDTH-1]) || !(|w_prod[2*WIDTH-1:WIDTH-1]));
  assign w_quo = r_sign ? -r_quo : r_quo;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    // NOTE: defaulting w_next before the case keeps every path assigned, so no latch is inferred.
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (ctrl_MULT)     w_next = S_MULT;
        else if (ctrl_DIV) w_next = S_DIV;
        else               w_next = S_IDLE;
      end
      S_MULT, S_DIV: begin
        if (w_last) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand capture, iteration and result write-back
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
      r_count     <= '0;
      r_acc       <= '0;
      r_opnd      <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_sign      <= 1'b0;
      r_exc       <= 1'b0;
      r_rd        <= '0;
      r_result    <= '0;
      r_exception <= 1'b0;
      r_rd_out    <= '0;
    end else if (w_start) begin
      r_sign  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      r_rd    <= rd_in;
      r_count <= w_skip ? CW'(ITER) : '0;
      r_exc   <= w_div_zero || w_div_ovf;
      r_rem   <= '0;
      if (ctrl_MULT) begin
        r_opnd <= w_mag_a;
        r_acc  <= w_early ? '0 : {{WIDTH{1'b0}}, w_mag_b};
      end else begin
        r_opnd <= w_mag_b;
        r_quo  <= w_mag_a;
      end
    end else if (r_state == S_MULT) begin
      if (!w_last) begin
        r_acc   <= {w_mul_sum, r_acc[WIDTH-1:1]};
        r_count <= r_count + CW'(1);
      end else if (w_mul_ovf) begin
        r_result    <= WIDTH'(MUL_ERR_CODE);
        r_exception <= 1'b1;
        r_rd_out    <= 5'(STATUS_REG);
      end else begin
        r_result    <= w_prod[WIDTH-1:0];
        r_exception <= 1'b0;
        r_rd_out    <= r_rd;
      end
    end else if (r_state == S_DIV) begin
      if (!w_last) begin
        r_rem   <= w_ge ? w_sub : w_shift[WIDTH:0];
        r_quo   <= {r_quo[WIDTH-2:0], w_ge};
        r_count <= r_count + CW'(1);
      end else if (r_exc) begin
        r_result    <= WIDTH'(DIV_ERR_CODE);
        r_exception <= 1'b1;
        r_rd_out    <= 5'(STATUS_REG);
      end else begin
        r_result    <= w_quo;
        r_exception <= 1'b0;
        r_rd_out    <= r_rd;
      end
    end
  end

  assign busy           = (r_state == S_MULT) || (r_state == S_DIV);
  assign data_resultRDY = (r_state == S_DONE);
  assign data_result    = r_result;
  assign data_exception = r_exception;
  assign rd_out         = r_rd_out;

endmodule

// File: tb/tb_multdiv_unit.sv
// -----------------------------------------------------------------------------
// tb_multdiv_unit
//
// Self-checking bench for multdiv_unit. A transaction-level model computes
// each accepted operation's result with plain signed arithmetic and predicts
// the cycle of its ready pulse; a compare process checks busy/RDY every cycle
// and the result fields on each RDY. Directed cases pin literal values, then
// randomized starts (including ones issued while busy, and resets) follow.
// -----------------------------------------------------------------------------
module tb_multdiv_unit;

  localparam longint LMAX = 64'sd2147483647;
  localparam longint LMIN = -64'sd2147483648;

`ifdef MULTDIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [4:0]  rd_in = '0;
  logic        busy;
  logic        data_resultRDY;
  logic [31:0] data_result;
  logic        data_exception;
  logic [4:0]  rd_out;

  multdiv_unit dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .rd_in          (rd_in),
    .busy           (busy),
    .data_resultRDY (data_resultRDY),
    .data_result    (data_result),
    .data_exception (data_exception),
    .rd_out         (rd_out)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Model of the one operation the unit can hold.
  bit          cur_valid = 1'b0;
  int          cur_rdy   = 0;
  int          last_e0   = 0;
  logic [31:0] cur_res   = '0;
  bit          cur_exc   = 1'b0;
  logic [4:0]  cur_rd    = '0;
  bit          chk_en    = 1'b0;
  bit          zero_chk  = 1'b0;
  bit          exp_rdy;
  bit          exp_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_op(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] rd, output logic [31:0] res,
                                   output bit exc, output logic [4:0] rdo, output int lat);
    longint p;
    int     q;
    bit     early;
    early = 1'b0;
`ifdef MULTDIV_EARLY_OUT_EN
    early = (a == 0) || (is_mul && b == 0);
`endif
    lat = 33;
    exc = 1'b0;
    if (is_mul) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      exc = (p > LMAX) || (p < LMIN);
      res = exc ? 32'd4 : 32'(p);
    end else if (b == 0) begin
      exc = 1'b1;
      res = 32'd5;
      lat = 1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      exc = 1'b1;
      res = 32'd5;
    end else begin
      q   = $signed(a) / $signed(b);
      res = q;
    end
    if (early && !exc) lat = 1;
    rdo = exc ? 5'd30 : rd;
  endfunction

  // Compare process: runs on the falling edge, before the driver touches inputs.
  always @(negedge clock) begin
    if (chk_en) begin
      exp_rdy  = cur_valid && (cyc == cur_rdy);
      exp_busy = cur_valid && (cyc < cur_rdy);
      check("rdy", data_resultRDY, exp_rdy);
      check("busy", busy, exp_busy);
      if (exp_rdy) begin
        check("result", data_result, cur_res);
        check("exception", data_exception, cur_exc);
        check("rd_out", rd_out, cur_rd);
      end
      if (zero_chk) begin
        check("rst_result", data_result, 0);
        check("rst_exception", data_exception, 0);
        check("rst_rd_out", rd_out, 0);
        zero_chk = 1'b0;
      end
    end
  end

  // Drives one cycle of inputs (called just after a falling edge) and returns
  // just after the next falling edge with the start pulses dropped.
  task automatic drive_cycle(input bit m, input bit d, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd);
    logic [31:0] r;
    bit          e;
    logic [4:0]  ro;
    int          l;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    rd_in         = rd;
    if ((m || d) && (!cur_valid || cur_rdy <= cyc)) begin
      model_op(m, a, b, rd, r, e, ro, l);
      cur_valid = 1'b1;
      last_e0   = cyc + 1;
      cur_rdy   = cyc + 1 + l;
      cur_res   = r;
      cur_exc   = e;
      cur_rd    = ro;
    end
    @(negedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cur_valid = 1'b0;
    zero_chk  = 1'b1;
    @(negedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_rdy(input string name, input logic [31:0] lit_res, input bit lit_exc,
                          input logic [4:0] lit_rd, input int lit_lat);
    bit seen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (data_resultRDY) begin
        seen = 1'b1;
        break;
      end
      drive_cycle(0, 0, '0, '0, '0);
    end
    check({name, "_seen"}, seen, 1);
    check({name, "_model"}, cur_res, lit_res);
    if (seen) begin
      check({name, "_lat"}, cyc - last_e0, lit_lat);
      check({name, "_res"}, data_result, lit_res);
      check({name, "_exc"}, data_exception, lit_exc);
      check({name, "_rd"}, rd_out, lit_rd);
    end
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      4, 5:    return 32'($urandom_range(0, 200)) - 32'd100;
      6:       return {{16{1'b0}}, 16'($urandom)} - 32'h8000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clock);
    #1;
    chk_en = 1'b1;
    do_reset();

    // Directed cases with hand-computed results.
    drive_cycle(1, 0, 32'd7, -32'sd6, 5'd9);
    wait_rdy("mul_7x-6", 32'hFFFF_FFD6, 0, 5'd9, 33);

    drive_cycle(0, 1, -32'sd100, 32'd7, 5'd3);
    wait_rdy("div_-100/7", 32'hFFFF_FFF2, 0, 5'd3, 33);

    drive_cycle(0, 1, 32'd5, 32'd0, 5'd4);
    wait_rdy("div_by_zero", 32'd5, 1, 5'd30, 1);
    drive_cycle(1, 0, 32'h0001_0000, 32'h0001_0000, 5'd12);
    wait_rdy("mul_ovf", 32'd4, 1, 5'd30, 33);

    drive_cycle(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2);
    wait_rdy("div_intmin", 32'd5, 1, 5'd30, 33);

    drive_cycle(1, 0, 32'd3, 32'd4, 5'd6);
    repeat (9) drive_cycle(0, 0, '0, '0, '0);
    drive_cycle(0, 1, 32'd100, 32'd7, 5'd1);
    wait_rdy("mul_3x4", 32'd12, 0, 5'd6, 33);
    drive_cycle(1, 0, 32'd2, 32'd2, 5'd7);
    wait_rdy("b2b_2x2", 32'd4, 0, 5'd7, 33);

    drive_cycle(1, 1, 32'd5, 32'd5, 5'd10);
    repeat (14) drive_cycle(0, 0, '0, '0, '0);
    do_reset();
    drive_cycle(0, 1, 32'd9, 32'd3, 5'd11);
    wait_rdy("div_after_rst", 32'd3, 0, 5'd11, 33);

    drive_cycle(1, 0, 32'd0, 32'd123, 5'd8);
    wait_rdy("mul_zero", 32'd0, 0, 5'd8, EARLY_LAT);

    drive_cycle(1, 1, -32'sd9, 32'd11, 5'd13);
    wait_rdy("mul_wins", 32'hFFFF_FF9D, 0, 5'd13, 33);

    // Randomized traffic; starts while busy are ignored by the model too.
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset();
      end else if (r < 20) begin
        bit m = 1'($urandom);
        bit d = 1'($urandom);
        if (!m && !d) d = 1'b1;
        drive_cycle(m, d, rand_op(), rand_op(), 5'($urandom));
      end else begin
        drive_cycle(0, 0, $urandom, $urandom, 5'($urandom));
      end
    end
    repeat (40) drive_cycle(0, 0, '0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
